// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the memory arbiter.
//   ADDR_W       - byte address width of the memory bus
//   DATA_W       - data width of the memory bus
//   CNT_W        - width of the per-access wait counter (covers WAIT 0..15)
//   WAIT_DEFAULT - default number of extra wait cycles per access
//   owner_t      - bus owner encoding (OWN_CPU=0, OWN_DMA=1)
package bus_arbiter_pkg;

  localparam int          ADDR_W       = 20;
  localparam int          DATA_W       = 8;
  localparam int          CNT_W        = 4;
  localparam int unsigned WAIT_DEFAULT = 1;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/bus_arbiter.sv
// Memory bus arbiter between a CPU and a DMA requester.
// Every access lasts WAIT+1 cycles; the last one is the completion cycle,
// where the strobe for the current owner fires and the next owner is chosen.
// After a CPU access the DMA gets the bus if it is requesting; after a DMA
// access the CPU always gets it back, so the CPU can never be starved.
//
// Ports
//   clock, reset_n         clock and synchronous active-low reset
//   cpu_address/out/we     CPU access request (always present)
//   cpu_in                 read data to CPU (copy of mem_rdata)
//   cpu_locked             CPU access completes this cycle
//   dma_req/address/we/wdata  DMA access request, held until dma_ack
//   dma_rdata              registered DMA read data
//   dma_ack                DMA access completes this cycle
//   mem_address/wdata/we   memory side; mem_we is a one-cycle strobe
//   mem_rdata              memory read data, combinational from mem_address
//
// state | meaning
// ------+-------------------------------------------------------------
// CPU   | current access belongs to the CPU; cnt counts its wait cycles
// DMA   | current access belongs to the DMA; cnt counts its wait cycles
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT = WAIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_in,
  output logic              cpu_locked,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done;
  logic             rdata_load;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      owner     <= OWN_CPU;
      cnt       <= '0;
      dma_rdata <= '0;
    end else begin
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      if (rdata_load) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

  // Strobes are qualified with reset_n so an access cut short by reset
  // never shows a completion or writes memory in the cycle reset is held.
  always_comb begin
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    cpu_locked = 1'b0;
    dma_ack    = 1'b0;
    mem_we     = 1'b0;
    rdata_load = 1'b0;
    done       = (cnt == WAIT_C);

    if (!done) begin
      cnt_nxt = cnt + 1'b1;
    end else begin
      cnt_nxt = '0;
      case (owner)
        OWN_CPU: begin
          cpu_locked = reset_n;
          mem_we     = cpu_we & reset_n;
          owner_nxt  = dma_req ? OWN_DMA : OWN_CPU;
        end
        OWN_DMA: begin
          dma_ack    = reset_n;
          mem_we     = dma_we & reset_n;
          rdata_load = ~dma_we;
          owner_nxt  = OWN_CPU;
        end
        default: begin
          owner_nxt = OWN_CPU;
        end
      endcase
    end
  end

  assign mem_address = (owner == OWN_DMA) ? dma_address : cpu_address;
  assign mem_wdata   = (owner == OWN_DMA) ? dma_wdata   : cpu_out;
  assign cpu_in      = mem_rdata;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WAIT, default 1; extra wait cycles per memory access (0..15), so each access lasts WAIT+1 cycles.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 cpu_address  input  20  CPU byte address.
REQ-005 cpu_out  input  8  CPU write data.
REQ-006 cpu_we  input  1  CPU write request.
REQ-007 cpu_in  output  8  read data to CPU, combinational copy of mem_rdata.
REQ-008 cpu_locked  output  1  one-cycle strobe: the CPU access completes this cycle and the core may advance one phase.
REQ-009 dma_req  input  1  DMA access request, held until dma_ack.
REQ-010 dma_address  input  20  DMA byte address, stable while dma_req is high.
REQ-011 dma_we  input  1  DMA write when 1, read when 0.
REQ-012 dma_wdata  input  8  DMA write data.
REQ-013 dma_rdata  output  8  registered DMA read data.
REQ-014 dma_ack  output  1  one-cycle strobe: the DMA access completes this cycle.
REQ-015 mem_address  output  20  memory address.
REQ-016 mem_wdata  output  8  memory write data.
REQ-017 mem_we  output  1  one-cycle memory write strobe.
REQ-018 mem_rdata  input  8  memory read data, valid combinationally from mem_address.

Function
REQ-019 The arbiter SHALL hold an owner register (CPU or DMA) and a wait counter cnt, 0..WAIT.
REQ-020 mem_address and mem_wdata SHALL come combinationally from the current owner's address and data.
REQ-021 cnt SHALL increment each cycle while cnt<WAIT; the cycle where cnt==WAIT is the completion cycle.
REQ-022 In the completion cycle, cnt SHALL return to 0 and the owner for the next access SHALL be selected.
REQ-023 On a CPU completion cycle: cpu_locked=1, and mem_we=cpu_we.
REQ-024 On a DMA completion cycle: dma_ack=1, mem_we=dma_we, and dma_rdata<=mem_rdata if dma_we=0.
REQ-025 mem_we, cpu_locked and dma_ack SHALL be 0 in every non-completion cycle; at most one of cpu_locked or dma_ack SHALL be high in any cycle.
REQ-026 Next owner after a CPU access: DMA if dma_req=1 in that completion cycle, else CPU.
REQ-027 Next owner after a DMA access: always CPU (strict alternation; DMA gets at most 50% of accesses; CPU is never starved).
REQ-028 A DMA access, once started, SHALL complete and issue dma_ack even if dma_req falls mid-access.
REQ-029 dma_req still high in the cycle after dma_ack SHALL count as a new request.
REQ-030 dma_rdata SHALL hold its value until the next DMA read completes.
REQ-031 With WAIT=0, every cycle SHALL be a completion cycle.
REQ-032 With dma_req low, cpu_locked SHALL pulse every WAIT+1 cycles.

Reset
REQ-033 While reset_n=0, sampled at a clock edge: owner=CPU, cnt=0, dma_rdata=0, and cpu_locked=dma_ack=mem_we=0.
REQ-034 Reset mid-access SHALL abort the access with no strobe and no memory write; an aborted DMA requester SHALL re-present its request.
REQ-035 The first access after reset release SHALL be a CPU access.

Structure
REQ-036 The following SHALL live in the shared bus package/include: owner encodings (OWN_CPU=0, OWN_DMA=1), the default WAIT, and the 20-bit address width constant.
REQ-037 The block SHALL be a single module with no sub-module; the address/data mux and the FSM are too small to split.

Verification
REQ-038 WAIT=1, dma_req=0, cpu_we=0, mem model returns 8'hA5 at 20'hFFFF0 -> cpu_locked high every 2nd cycle, cpu_in=8'hA5, mem_we never high.
REQ-039 WAIT=1, CPU write 8'h3C to 20'h00100 -> exactly one mem_we pulse, coincident with cpu_locked, with mem_address=20'h00100 and mem_wdata=8'h3C.
REQ-040 WAIT=2, dma_req held high continuously, DMA reads 20'h0B800 (memory value 8'h41) -> ack and locked alternate, each pulse 3 cycles apart; dma_rdata=8'h41 after the first dma_ack.
REQ-041 WAIT=0, dma_req raised for one request -> exactly one DMA access, inserted right after the current CPU completion, then CPU accesses resume every cycle.
REQ-042 WAIT=3, reset_n pulled low in cnt=2 of a DMA write -> no mem_we and no dma_ack; after release, the first strobe is cpu_locked, 4 cycles later.
REQ-043 dma_req dropped after the first cycle of a DMA access (WAIT=1) -> dma_ack still issued once, then owner returns to CPU.
